// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet action path: action indices, bus widths,
// the issuer FSM state type and small helpers used by the issuer RTL.
package tamagotchi_pkg;

  localparam int ACT_HUNGER    = 0;
  localparam int ACT_HAPPINESS = 1;
  localparam int ACT_HEALTH    = 2;
  localparam int ACT_HYGIENE   = 3;
  localparam int ACT_ENERGY    = 4;
  localparam int ACT_SOCIAL    = 5;

  localparam int NUM_ACTIONS_DEF = 6;
  localparam int ACTION_BUS_W    = 8;
  localparam int ACTION_IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } issuer_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot action bus for an index; indices outside the action table
  // (including the two spare top bits) never light up.
  function automatic logic [ACTION_BUS_W-1:0] action_onehot(input logic [ACTION_IDX_W-1:0] idx);
    logic [ACTION_BUS_W-1:0] bus;
    bus = '0;
    if (int'(idx) < NUM_ACTIONS_DEF) bus[idx] = 1'b1;
    return bus;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, consecutive-sample debounce
// counter, and a one-cycle registered press pulse on each accepted 0->1 change.
module btn_debounce
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        press <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/action_issuer.sv
// Turns the debounced next/select buttons into single-cycle one-hot action
// pulses for the stats block, with a wrapping menu cursor and a cooldown
// after every issued action.
// Optional build macro ACTION_AUTO_REPEAT_EN: when defined, a select button
// still held at the end of cooldown re-issues the action under the cursor.
module action_issuer
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int COOLDOWN_CYCLES = 27000000,
  parameter int NUM_ACTIONS     = NUM_ACTIONS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_next,
  input  logic                    btn_select,
  output logic [ACTION_BUS_W-1:0] actions,
  output logic [ACTION_IDX_W-1:0] cursor,
  output logic                    busy,
  output logic [ACTION_IDX_W-1:0] last_action
);

  localparam int COOL_W = cnt_width(COOLDOWN_CYCLES);
  localparam logic [COOL_W-1:0]       COOL_LOAD   = COOL_W'(COOLDOWN_CYCLES - 1);
  localparam logic [ACTION_IDX_W-1:0] CURSOR_LAST = ACTION_IDX_W'(NUM_ACTIONS - 1);

`ifdef ACTION_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  logic          next_press;
  logic          unused_next_level;
  logic          sel_press;
  logic          sel_level;
  issuer_state_t state;
  issuer_state_t state_next;
  logic [COOL_W-1:0] cool_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_next),
    .level  (unused_next_level),
    .press  (next_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_select (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_select),
    .level  (sel_level),
    .press  (sel_press)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: one ISSUE cycle, then a full cooldown; selects while busy are dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (sel_press) state_next = ISSUE;
      ISSUE:    state_next = COOLDOWN;
      COOLDOWN: if (cool_cnt == '0) state_next = (AUTO_REPEAT && sel_level) ? ISSUE : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs: busy covers ISSUE and COOLDOWN.
  always_comb begin
    busy = (state != IDLE);
  end

  // Registered action pulse; the index is captured from the cursor before any same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      actions     <= '0;
      last_action <= '0;
    end else if (state_next == ISSUE) begin
      actions     <= action_onehot(cursor);
      last_action <= cursor;
    end else begin
      actions <= '0;
    end
  end

  // Cooldown counter: loaded while in ISSUE, counts down to zero through COOLDOWN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cool_cnt <= '0;
    end else if (state == ISSUE) begin
      cool_cnt <= COOL_LOAD;
    end else if (state == COOLDOWN && cool_cnt != '0) begin
      cool_cnt <= cool_cnt - 1'b1;
    end
  end

  // Menu cursor advances on every next press, in any FSM state, wrapping at the last action.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor <= '0;
    end else if (next_press) begin
      cursor <= (cursor == CURSOR_LAST) ? '0 : cursor + 1'b1;
    end
  end

endmodule
